instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2: instruction buffer entries, which also caps outstanding memory requests; legal values are 2 and 4.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 pc  out  32  current fetch PC, driven to the predictor lookup.
REQ-006 br_taken  in  1  predictor taken flag for pc, combinational, same cycle.
REQ-007 bp_target  in  32  predicted target for pc, valid when br_taken=1.
REQ-008 redirect  in  1  mispredict/jump correction from execute.
REQ-009 redirect_pc  in  32  corrected fetch address.
REQ-010 imem_req  out  1  memory request valid.
REQ-011 imem_addr  out  32  request address, equal to {pc[31:2],2'b00}.
REQ-012 imem_gnt  in  1  request accepted this cycle.
REQ-013 imem_rvalid  in  1  read data valid; responses return in order, at least 1 cycle after gnt.
REQ-014 imem_rdata  in  32  instruction word.
REQ-015 if_valid  out  1  buffer head valid to decode.
REQ-016 if_instr / if_pc  out  32 / 32  head instruction and its PC.
REQ-017 if_pred_taken  out  1  prediction recorded for the head.
REQ-018 stall  in  1  decode cannot accept; head pops when if_valid & ~stall.

Function
REQ-019 SHALL implement an FSM with states BOOT and RUN: BOOT lasts exactly 1 cycle after rstn rises with imem_req=0, then RUN is held until reset.
REQ-020 In RUN, imem_req SHALL be 1 iff (buffered + outstanding) < DEPTH and redirect=0.
REQ-021 On a grant without redirect, the pc update SHALL be pc <= br_taken ? bp_target : pc+4, with 32-bit wraparound at 32'hFFFF_FFFC -> 0.
REQ-022 On a grant, {pc, br_taken} SHALL be pushed into an in-flight tag queue of DEPTH entries.
REQ-023 On imem_rvalid with discard count 0, the head tag plus imem_rdata SHALL be written to the instruction buffer.
REQ-024 Fetch-to-decode latency SHALL be 1 cycle: data captured on the rvalid edge appears at if_valid on the next cycle.
REQ-025 Redirect SHALL take priority over every other event and set pc <= redirect_pc.
REQ-026 Redirect SHALL flush the instruction buffer and tag queue.
REQ-027 Redirect SHALL set the discard count to the number of outstanding requests, including one granted in the same cycle.
REQ-028 Each rvalid arriving while discard > 0 SHALL be dropped and SHALL decrement discard.
REQ-029 New requests SHALL be allowed while discard > 0, still subject to the REQ-020 cap, counting discards as outstanding.
REQ-030 A simultaneous pop and rvalid write on a full buffer SHALL be legal; a write without space SHALL never occur, by construction of REQ-020.
REQ-031 The pred_taken bit is informational only: the predictor owns training.

Reset
REQ-032 While rstn=0, the following SHALL hold: pc=RESET_PC, imem_req=0, if_valid=0, if_instr=0, if_pc=0, if_pred_taken=0, buffer/queue/discard count=0, FSM=BOOT.
REQ-033 Reset asserted mid-transaction SHALL abandon outstanding requests; the memory side is reset by the same rstn.

Configuration
REQ-034 With IFU_PERF_CNT_EN defined, the block SHALL add outputs perf_fetched[31:0], counting instructions popped to decode, and perf_discarded[31:0], counting responses dropped plus entries flushed; both reset to 0 and wrap at 2^32.
REQ-035 Without IFU_PERF_CNT_EN, these ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-036 The shared package SHALL hold the FSM state encoding (BOOT, RUN), the fetch-entry typedef {pc[31:0], instr[31:0], pred}, and the constant PC_INC=4.
REQ-037 One sub-module, fetch_fifo (parameterised depth, push/pop/flush, count output), SHALL be used for both the tag queue and the instruction buffer.

Verification
REQ-038 Reset release, gnt always 1, rvalid 1 cycle later, br_taken=0 -> first request at cycle 2 with addr 0x0, then 0x4, 0x8; decode sees pc 0x0 first.
REQ-039 Predicted taken: br_taken=1 and bp_target=0x100 at pc=0x8 -> next imem_addr 0x100, and entry pc=0x8 carries if_pred_taken=1.
REQ-040 Redirect with 2 outstanding requests, redirect_pc=0x200 -> buffer emptied, next 2 rvalids dropped, next delivered if_pc=0x200.
REQ-041 stall held 10 cycles with DEPTH=2 -> exactly 2 grants, then imem_req=0 until the first pop.
REQ-042 pc=0xFFFF_FFFC, not taken -> next pc 0x0000_0000.
REQ-043 With IFU_PERF_CNT_EN, scenario REQ-040 -> perf_discarded increments by 2 and perf_fetched counts only delivered instructions.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared FSM encoding, fetch-entry type and PC increment for the fetch unit
package instr_fetch_unit_pkg;
   typedef enum logic {BOOT, RUN} ifu_state_e;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred;
   } fetch_entry_t;
   localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory request/grant and in-order response bus
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
   modport slave (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// fetch_fifo: circular buffer of fetch entries with flush and occupancy count (DEPTH a power of two)
module fetch_fifo
   import instr_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  din,
   output fetch_entry_t  dout,
   output logic [CW-1:0] count
);
   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic          do_pop, do_push;
   assign do_pop = pop && count != '0;
   // a push into a full fifo is legal only when the head leaves in the same cycle
   assign do_push = push && (count != CW'(DEPTH) || do_pop);
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generation, in-order imem request tracking and decode-side instruction buffer.
// Define IFU_PERF_CNT_EN to add the perf_fetched / perf_discarded counters.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH = 2
) (
   input  logic               clk,
   input  logic               rstn,
   output logic [31:0]        pc,
   input  logic               br_taken,
   input  logic [31:0]        bp_target,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   instr_fetch_unit_if.master imem,
   output logic               if_valid,
   output logic [31:0]        if_instr,
   output logic [31:0]        if_pc,
   output logic               if_pred_taken,
   input  logic               stall
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_discarded
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;
   ifu_state_e    state, state_nxt;
   logic [CW-1:0] tq_count, buf_count, discard;
   fetch_entry_t  tq_din, tag, buf_din, head;
   logic          gnt_fire, deliver, drop, pop;
   assign gnt_fire = imem.imem_req && imem.imem_gnt;
   assign deliver = imem.imem_rvalid && discard == '0;
   assign drop = imem.imem_rvalid && discard != '0;
   assign pop = if_valid && !stall;
   assign imem.imem_addr = {pc[31:2], 2'b00};
   assign tq_din = '{pc: pc, instr: '0, pred: br_taken};
   assign if_valid = buf_count != '0;
   assign {if_pc, if_instr, if_pred_taken} = head;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= BOOT;
      else state <= state_nxt;
   // discards still occupy a slot: their responses have yet to arrive
   always_comb begin
      state_nxt = (state == BOOT) ? RUN : state;
      imem.imem_req = (state == RUN) && !redirect &&
                      (int'(buf_count) + int'(tq_count) + int'(discard) < DEPTH);
   end
   always_comb begin
      buf_din = tag;
      buf_din.instr = imem.imem_rdata;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) pc <= RESET_PC;
      else if (redirect) pc <= redirect_pc;
      else if (gnt_fire) pc <= br_taken ? bp_target : pc + PC_INC;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) discard <= '0;
      else if (redirect) discard <= tq_count + discard + CW'(gnt_fire) - CW'(imem.imem_rvalid);
      else if (drop) discard <= discard - 1'b1;
   fetch_fifo #(.DEPTH(DEPTH)) u_tag_q (
      .clk(clk), .rstn(rstn), .push(gnt_fire), .pop(deliver), .flush(redirect),
      .din(tq_din), .dout(tag), .count(tq_count)
   );
   fetch_fifo #(.DEPTH(DEPTH)) u_ibuf (
      .clk(clk), .rstn(rstn), .push(deliver), .pop(pop), .flush(redirect),
      .din(buf_din), .dout(head), .count(buf_count)
   );
`ifdef IFU_PERF_CNT_EN
   logic dropped;
   assign dropped = imem.imem_rvalid && (discard != '0 || redirect);
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         perf_fetched <= '0;
         perf_discarded <= '0;
      end else begin
         perf_fetched <= perf_fetched + 32'(pop);
         perf_discarded <= perf_discarded + 32'(dropped) +
                           (redirect ? 32'(buf_count) - 32'(pop) : 32'd0);
      end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed table plus multi-cycle sequences for instr_fetch_unit (DEPTH=2).
`timescale 1ns/1ps
module tb_instr_fetch_unit;
   typedef struct packed {
      logic        stall;
      logic        bt;
      logic [31:0] tgt;
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] ipc;
      logic        ipred;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] pc;
   logic        br_taken = 1'b0;
   logic [31:0] bp_target = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid, if_pred_taken;
   logic [31:0] if_instr, if_pc;
   logic        stall = 1'b0;
   logic        rv_en = 1'b1;
   logic [31:0] q [$];
   int          checks = 0;
   int          errors = 0;
   vec_t        tbl [9];
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_discarded;
`endif

   instr_fetch_unit_if mif ();

   instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk(clk), .rstn(rstn), .pc(pc), .br_taken(br_taken), .bp_target(bp_target),
      .redirect(redirect), .redirect_pc(redirect_pc), .imem(mif),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .if_pred_taken(if_pred_taken), .stall(stall)
`ifdef IFU_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_discarded(perf_discarded)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // memory model: grants always, answers in order one or more cycles after the grant, data = ~addr
   task automatic tick();
      #1;
      if (mif.imem_rvalid) void'(q.pop_front());
      if (mif.imem_req && mif.imem_gnt) q.push_back(mif.imem_addr);
      @(posedge clk);
      #1;
      mif.imem_rvalid = rv_en && q.size() > 0;
      mif.imem_rdata = q.size() > 0 ? ~q[0] : 32'h0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      redirect = 1'b0;
      stall = 1'b0;
      br_taken = 1'b0;
      rv_en = 1'b1;
      mif.imem_gnt = 1'b1;
      mif.imem_rvalid = 1'b0;
      mif.imem_rdata = '0;
      q.delete();
      #3;
      chk("rst_pc", pc, 32'h0);
      chk("rst_req", 32'(mif.imem_req), 32'h0);
      chk("rst_if_valid", 32'(if_valid), 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_pred", 32'(if_pred_taken), 32'h0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic wait_valid(input string name, input logic [31:0] exp, output int nrv);
      int n;
      n = 0;
      nrv = 0;
      while (!if_valid && n < 20) begin
         if (mif.imem_rvalid) nrv++;
         tick();
         #1;
         n++;
      end
      chk({name, "_valid"}, 32'(if_valid), 32'h1);
      chk({name, "_pc"}, if_pc, exp);
      chk({name, "_instr"}, if_instr, ~exp);
   endtask

   initial begin
      int grants, nrv;
      tbl[0] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b0, 32'h000, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h000, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 32'h100, 1'b1, 32'h008, 1'b1, 32'h004, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 32'h008, 1'b1};
      tbl[7] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 1'b0};
      tbl[8] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b0, 32'h000, 1'b0};

      // boot cycle, sequential stream and a predicted-taken branch at pc 0x8
      do_reset();
      for (int i = 0; i < 9; i++) begin
         stall = tbl[i].stall;
         br_taken = tbl[i].bt;
         bp_target = tbl[i].tgt;
         #1;
         chk($sformatf("row%0d_req", i), 32'(mif.imem_req), 32'(tbl[i].req));
         chk($sformatf("row%0d_addr", i), mif.imem_addr, tbl[i].addr);
         chk($sformatf("row%0d_valid", i), 32'(if_valid), 32'(tbl[i].v));
         if (tbl[i].v) begin
            chk($sformatf("row%0d_if_pc", i), if_pc, tbl[i].ipc);
            chk($sformatf("row%0d_pred", i), 32'(if_pred_taken), 32'(tbl[i].ipred));
            chk($sformatf("row%0d_instr", i), if_instr, ~tbl[i].ipc);
         end
         tick();
      end
      br_taken = 1'b0;

      // decode stalled for 10 cycles: two grants, then no request until a pop
      do_reset();
      stall = 1'b1;
      grants = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (mif.imem_req && mif.imem_gnt) grants++;
         tick();
      end
      #1;
      chk("stall_grants", 32'(grants), 32'd2);
      chk("stall_req_off", 32'(mif.imem_req), 32'h0);
      chk("stall_head", if_pc, 32'h0);
      stall = 1'b0;
      #1;
      chk("stall_pop_req", 32'(mif.imem_req), 32'h0);
      tick();
      #1;
      chk("stall_resume_req", 32'(mif.imem_req), 32'h1);
      chk("stall_resume_addr", mif.imem_addr, 32'h8);
      chk("stall_resume_head", if_pc, 32'h4);

      // redirect with a full buffer: buffer flushed, fetch restarts at 0x300
      do_reset();
      stall = 1'b1;
      repeat (6) tick();
      redirect = 1'b1;
      redirect_pc = 32'h300;
      #1;
      chk("flush_req_blocked", 32'(mif.imem_req), 32'h0);
      tick();
      redirect = 1'b0;
      stall = 1'b0;
      #1;
      chk("flush_empty", 32'(if_valid), 32'h0);
      chk("flush_req", 32'(mif.imem_req), 32'h1);
      chk("flush_addr", mif.imem_addr, 32'h300);
`ifdef IFU_PERF_CNT_EN
      chk("flush_perf_disc", perf_discarded, 32'd2);
`endif
      wait_valid("flush_first", 32'h300, nrv);

      // redirect with two requests in flight: both responses dropped, then 0x200 delivered
      do_reset();
      rv_en = 1'b0;
      repeat (4) tick();
      #1;
      chk("drop_full_req", 32'(mif.imem_req), 32'h0);
      chk("drop_no_valid", 32'(if_valid), 32'h0);
      redirect = 1'b1;
      redirect_pc = 32'h200;
      rv_en = 1'b1;
      #1;
      chk("drop_redir_req", 32'(mif.imem_req), 32'h0);
      tick();
      redirect = 1'b0;
      #1;
      chk("drop_discard_req", 32'(mif.imem_req), 32'h0);
      wait_valid("drop_first", 32'h200, nrv);
      chk("drop_rvalid_count", 32'(nrv), 32'd3);
`ifdef IFU_PERF_CNT_EN
      chk("drop_perf_disc", perf_discarded, 32'd2);
      chk("drop_perf_fetch0", perf_fetched, 32'd0);
      tick();
      #1;
      chk("drop_perf_fetch1", perf_fetched, 32'd1);
`endif

      // pc wraparound from 0xFFFF_FFFC to 0
      do_reset();
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      #1;
      chk("wrap_req", 32'(mif.imem_req), 32'h1);
      chk("wrap_addr_hi", mif.imem_addr, 32'hFFFF_FFFC);
      tick();
      #1;
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_addr_lo", mif.imem_addr, 32'h0);
      wait_valid("wrap_first", 32'hFFFF_FFFC, nrv);
      tick();
      #1;
      chk("wrap_second_pc", if_pc, 32'h0);
      chk("wrap_second_valid", 32'(if_valid), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
